// File: rtl/bus_pkg.sv
// bus_pkg: shared types and widths for the processor data bus.
//   BUS_AW / BUS_DW / BUS_BEW : word address, data and byte-enable widths
//   master_id_t               : which upstream master owns a transaction
//   read_tag_t                : {valid, id} carried alongside an outstanding read
package bus_pkg;

    localparam int unsigned BUS_AW  = 30;
    localparam int unsigned BUS_DW  = 32;
    localparam int unsigned BUS_BEW = 4;

    typedef enum logic {
        M_CORE   = 1'b0,
        M_LOADER = 1'b1
    } master_id_t;

    typedef struct packed {
        logic       valid;
        master_id_t id;
    } read_tag_t;

    function automatic master_id_t other_master(master_id_t id);
        return (id == M_CORE) ? M_LOADER : M_CORE;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: one data-bus port.
//   address / writeenable / writedata / byteena / readenable : request, issuer -> target
//   waitrequest   : request not accepted this cycle, target -> issuer
//   readdata      : read return data, target -> issuer
//   readdatavalid : readdata belongs to this issuer, target -> issuer
// The master modport is the arbiter's downstream side: the slave has fixed read
// latency and never stalls, so only readdata comes back on it.
interface bus_arbiter_if;
    import bus_pkg::*;

    logic [BUS_AW-1:0]  address;
    logic               writeenable;
    logic [BUS_DW-1:0]  writedata;
    logic [BUS_BEW-1:0] byteena;
    logic               readenable;
    logic               waitrequest;
    logic [BUS_DW-1:0]  readdata;
    logic               readdatavalid;

    modport master (
        output address, writeenable, writedata, byteena, readenable,
        input  readdata
    );

    modport slave (
        input  address, writeenable, writedata, byteena, readenable,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/read_tag_pipe.sv
// read_tag_pipe: fixed-depth shift register of read tags, one stage per cycle of
// slave read latency.
//   clk, reset_n : clock, asynchronous active-low reset (clears all tags)
//   tag_in       : tag pushed this cycle ({0, x} when no read is accepted)
//   tag_out      : tag whose read data is on the slave bus this cycle
module read_tag_pipe
    import bus_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic      clk,
    input  logic      reset_n,
    input  read_tag_t tag_in,
    output read_tag_t tag_out
);

    read_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one downstream bus port between the core (m0) and the
// debug/loader master (m1). Round-robin with a bounded hold under contention;
// the losing requester sees waitrequest. Read returns are steered back to the
// issuing master by a tag pipe matching the slave's fixed read latency.
//   clk, reset_n : clock, asynchronous active-low reset
//   m0, m1       : upstream master ports
//   s            : downstream slave port (s_readdata valid READ_LATENCY cycles
//                  after an accepted read)
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_HOLD     = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    bus_arbiter_if.slave  m0,
    bus_arbiter_if.slave  m1,
    bus_arbiter_if.master s
);

    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    master_id_t owner_q, owner_d;
    logic [7:0] hold_q, hold_d;
    // Set after reset or a no-grant cycle: a fresh contest goes to the non-owner.
    logic       idle_q, idle_d;

    logic       m0_req, m1_req, other_req;
    logic       grant_valid;
    master_id_t grant_id;
    read_tag_t  tag_in, tag_out;

    assign m0_req = m0.readenable | m0.writeenable;
    assign m1_req = m1.readenable | m1.writeenable;

    always_comb begin : grant_logic
        grant_valid = 1'b1;
        grant_id    = owner_q;
        if (m0_req && m1_req) begin
            if (idle_q || hold_q == HoldLast) begin
                grant_id = other_master(owner_q);
            end
        end else if (m0_req) begin
            grant_id = M_CORE;
        end else if (m1_req) begin
            grant_id = M_LOADER;
        end else begin
            grant_valid = 1'b0;
        end
    end

    always_comb begin : slave_mux
        s.address     = '0;
        s.writeenable = 1'b0;
        s.writedata   = '0;
        s.byteena     = '0;
        s.readenable  = 1'b0;
        if (grant_valid) begin
            unique case (grant_id)
                M_CORE: begin
                    s.address     = m0.address;
                    s.writeenable = m0.writeenable;
                    s.writedata   = m0.writedata;
                    s.byteena     = m0.byteena;
                    s.readenable  = m0.readenable;
                end
                M_LOADER: begin
                    s.address     = m1.address;
                    s.writeenable = m1.writeenable;
                    s.writedata   = m1.writedata;
                    s.byteena     = m1.byteena;
                    s.readenable  = m1.readenable;
                end
                default: ;
            endcase
        end
    end

    assign m0.waitrequest = m0_req & ~(grant_valid & (grant_id == M_CORE));
    assign m1.waitrequest = m1_req & ~(grant_valid & (grant_id == M_LOADER));

    always_comb begin : next_state
        owner_d   = owner_q;
        hold_d    = '0;
        idle_d    = 1'b1;
        other_req = (grant_id == M_CORE) ? m1_req : m0_req;
        if (grant_valid) begin
            owner_d = grant_id;
            idle_d  = 1'b0;
            // Count only re-grants won against a waiting master; saturate, never wrap.
            if (grant_id == owner_q && other_req) begin
                hold_d = (hold_q == HoldLast) ? hold_q : hold_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= M_LOADER;
            hold_q  <= '0;
            idle_q  <= 1'b1;
        end else begin
            owner_q <= owner_d;
            hold_q  <= hold_d;
            idle_q  <= idle_d;
        end
    end

    assign tag_in = '{valid: grant_valid & s.readenable, id: grant_id};

    read_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_read_tag_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign m0.readdata      = s.readdata;
    assign m1.readdata      = s.readdata;
    assign m0.readdatavalid = tag_out.valid & (tag_out.id == M_CORE);
    assign m1.readdatavalid = tag_out.valid & (tag_out.id == M_LOADER);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: three arbiters (READ_LATENCY 1, 2, 3; MAX_HOLD 8) share the
// same master stimulus. A per-cycle model predicts grants, stalls, slave-side
// requests and read returns; directed scenarios add literal expectations.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int MaxHold = 8;
    localparam int NInst   = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  m_re = '0;
    logic [1:0]  m_we = '0;
    logic [29:0] m_addr [2];
    logic [31:0] m_wd [2];
    logic [3:0]  m_be [2];

    logic        o_w0 [NInst], o_w1 [NInst], o_dv0 [NInst], o_dv1 [NInst];
    logic [31:0] o_rd0 [NInst], o_rd1 [NInst], o_swd [NInst];
    logic [29:0] o_saddr [NInst];
    logic        o_swe [NInst], o_sre [NInst];
    logic [3:0]  o_sbe [NInst];

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] mem_data(input logic [29:0] a);
        return (a == 30'h2000_0000) ? 32'hDEAD_BEEF : ({2'b00, a} ^ 32'h5A5A_5A5A);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < NInst; k++) begin : g_dut
        bus_arbiter_if m0_bus ();
        bus_arbiter_if m1_bus ();
        bus_arbiter_if s_bus ();
        logic [31:0] rd_pipe [k+1];

        assign m0_bus.address     = m_addr[0];
        assign m0_bus.writeenable = m_we[0];
        assign m0_bus.writedata   = m_wd[0];
        assign m0_bus.byteena     = m_be[0];
        assign m0_bus.readenable  = m_re[0];
        assign m1_bus.address     = m_addr[1];
        assign m1_bus.writeenable = m_we[1];
        assign m1_bus.writedata   = m_wd[1];
        assign m1_bus.byteena     = m_be[1];
        assign m1_bus.readenable  = m_re[1];
        assign s_bus.waitrequest   = 1'b0;
        assign s_bus.readdatavalid = 1'b0;

        // Fixed-latency slave: data for an accepted read appears k+1 cycles later.
        always @(posedge clk) begin
            rd_pipe[0] <= s_bus.readenable ? mem_data(s_bus.address) : 32'hBAD0_0000;
            for (int i = 1; i <= k; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign s_bus.readdata = rd_pipe[k];

        bus_arbiter #(
            .READ_LATENCY (k + 1),
            .MAX_HOLD     (MaxHold)
        ) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .m0      (m0_bus),
            .m1      (m1_bus),
            .s       (s_bus)
        );

        assign o_w0[k]    = m0_bus.waitrequest;
        assign o_w1[k]    = m1_bus.waitrequest;
        assign o_dv0[k]   = m0_bus.readdatavalid;
        assign o_dv1[k]   = m1_bus.readdatavalid;
        assign o_rd0[k]   = m0_bus.readdata;
        assign o_rd1[k]   = m1_bus.readdata;
        assign o_saddr[k] = s_bus.address;
        assign o_swe[k]   = s_bus.writeenable;
        assign o_swd[k]   = s_bus.writedata;
        assign o_sbe[k]   = s_bus.byteena;
        assign o_sre[k]   = s_bus.readenable;
    end

    // ---------------- model and per-cycle compare ----------------
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } ret_t;

    ret_t rq [NInst][$];
    int   md_owner = 1;
    int   md_hold  = 0;
    bit   md_idle  = 1'b1;
    int   cyc      = 0;

    always @(negedge clk) begin
        int          g;
        bit          r0, r1, edv0, edv1;
        logic [29:0] ea;
        logic [31:0] ewd, edata;
        logic [3:0]  ebe;
        logic        ewe, ere;

        if (!reset_n) begin
            for (int k = 0; k < NInst; k++) rq[k].delete();
            md_owner = 1;
            md_hold  = 0;
            md_idle  = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            if (m_re[i] && m_we[i]) begin
                fails++;
                $display("FAIL illegal_req: master %0d drives read and write together", i);
            end
        end

        r0 = m_re[0] | m_we[0];
        r1 = m_re[1] | m_we[1];
        if (r0 && r1) begin
            if (md_idle || md_hold >= MaxHold - 1) g = 1 - md_owner;
            else g = md_owner;
        end else if (r0) g = 0;
        else if (r1) g = 1;
        else g = -1;

        if (g < 0) begin
            ea = '0; ewe = 1'b0; ewd = '0; ebe = '0; ere = 1'b0;
        end else begin
            ea = m_addr[g]; ewe = m_we[g]; ewd = m_wd[g]; ebe = m_be[g]; ere = m_re[g];
        end

        for (int k = 0; k < NInst; k++) begin
            chk("wait_m0", 32'(o_w0[k]), 32'(r0 && g != 0));
            chk("wait_m1", 32'(o_w1[k]), 32'(r1 && g != 1));
            chk("s_address", 32'(o_saddr[k]), 32'(ea));
            chk("s_writeenable", 32'(o_swe[k]), 32'(ewe));
            chk("s_writedata", o_swd[k], ewd);
            chk("s_byteena", 32'(o_sbe[k]), 32'(ebe));
            chk("s_readenable", 32'(o_sre[k]), 32'(ere));
            edv0 = 1'b0; edv1 = 1'b0; edata = '0;
            if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
                edv0  = (rq[k][0].id == 0);
                edv1  = (rq[k][0].id == 1);
                edata = rq[k][0].data;
                void'(rq[k].pop_front());
            end
            chk("readdatavalid_m0", 32'(o_dv0[k]), 32'(edv0));
            chk("readdatavalid_m1", 32'(o_dv1[k]), 32'(edv1));
            if (edv0 || edv1) begin
                chk("readdata_m0", o_rd0[k], edata);
                chk("readdata_m1", o_rd1[k], edata);
            end
        end

        if (reset_n) begin
            if (g >= 0 && m_re[g]) begin
                for (int k = 0; k < NInst; k++) begin
                    rq[k].push_back('{due: cyc + k + 1, id: g, data: mem_data(m_addr[g])});
                end
            end
            if (g >= 0) begin
                if (g == md_owner && (g == 0 ? r1 : r0))
                    md_hold = (md_hold + 1 > MaxHold - 1) ? MaxHold - 1 : md_hold + 1;
                else
                    md_hold = 0;
                md_owner = g;
                md_idle  = 1'b0;
            end else begin
                md_hold = 0;
                md_idle = 1'b1;
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic [29:0] a, input logic we,
                         input logic [31:0] wd, input logic [3:0] be, input logic re);
        m_addr[i] = a; m_we[i] = we; m_wd[i] = wd; m_be[i] = be; m_re[i] = re;
    endtask

    task automatic clr_m(input int i);
        set_m(i, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clr_m(0);
        clr_m(1);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    int gr [24];
    logic dv0_r [8], dv1_r [8];
    logic [31:0] rd0_r [8], rd1_r [8];

    initial begin
        clr_m(0);
        clr_m(1);
        do_reset();

        // Single master read, latency 1.
        set_m(0, 30'h2000_0000, 1'b0, '0, 4'hF, 1'b1);
        @(negedge clk);
        chk("t1_wait_m0", 32'(o_w0[0]), 32'd0);
        chk("t1_s_readenable", 32'(o_sre[0]), 32'd1);
        tick();
        clr_m(0);
        @(negedge clk);
        chk("t1_dv_m0", 32'(o_dv0[0]), 32'd1);
        chk("t1_data_m0", o_rd0[0], 32'hDEAD_BEEF);
        chk("t1_dv_m1", 32'(o_dv1[0]), 32'd0);
        chk("t1_dv_m0_lat2_early", 32'(o_dv0[1]), 32'd0);
        tick();

        // Continuous contest from reset: blocks of MaxHold cycles.
        do_reset();
        set_m(0, 30'h100, 1'b0, '0, 4'hF, 1'b1);
        set_m(1, 30'h200, 1'b0, '0, 4'hF, 1'b1);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            gr[c] = (o_saddr[0] == 30'h100) ? 0 : (o_saddr[0] == 30'h200) ? 1 : -1;
            if (c == 3) chk("t2_wait_m1_c3", 32'(o_w1[0]), 32'd1);
            if (c == 10) chk("t2_wait_m0_c10", 32'(o_w0[0]), 32'd1);
            tick();
        end
        clr_m(0);
        clr_m(1);
        chk("t2_grant_c0", 32'(gr[0]), 32'd0);
        chk("t2_grant_c7", 32'(gr[7]), 32'd0);
        chk("t2_grant_c8", 32'(gr[8]), 32'd1);
        chk("t2_grant_c15", 32'(gr[15]), 32'd1);
        chk("t2_grant_c16", 32'(gr[16]), 32'd0);
        for (int c = 0; c < 6; c++) tick();

        // Alternating reads, observed on the latency-3 instance.
        set_m(0, 30'h2000_0000, 1'b0, '0, 4'hF, 1'b1);
        for (int c = 0; c < 8; c++) begin
            if (c == 1) begin clr_m(0); set_m(1, 30'h10, 1'b0, '0, 4'hF, 1'b1); end
            if (c == 2) begin clr_m(1); set_m(0, 30'h20, 1'b0, '0, 4'hF, 1'b1); end
            if (c == 3) clr_m(0);
            @(negedge clk);
            dv0_r[c] = o_dv0[2]; dv1_r[c] = o_dv1[2];
            rd0_r[c] = o_rd0[2]; rd1_r[c] = o_rd1[2];
            tick();
        end
        chk("t3_dv_m0_c2", 32'(dv0_r[2]), 32'd0);
        chk("t3_dv_m0_c3", 32'(dv0_r[3]), 32'd1);
        chk("t3_dv_m1_c3", 32'(dv1_r[3]), 32'd0);
        chk("t3_data_c3", rd0_r[3], 32'hDEAD_BEEF);
        chk("t3_dv_m1_c4", 32'(dv1_r[4]), 32'd1);
        chk("t3_data_c4", rd1_r[4], 32'h5A5A_5A4A);
        chk("t3_dv_m0_c5", 32'(dv0_r[5]), 32'd1);
        chk("t3_data_c5", rd0_r[5], 32'h5A5A_5A7A);
        chk("t3_dv_c6", 32'(dv0_r[6] | dv1_r[6]), 32'd0);

        // Write from M1: forwarded, no response.
        set_m(1, 30'h2000_0000, 1'b1, 32'h0000_0041, 4'b0001, 1'b0);
        @(negedge clk);
        chk("t4_s_writeenable", 32'(o_swe[0]), 32'd1);
        chk("t4_s_writedata", o_swd[0], 32'h0000_0041);
        chk("t4_s_byteena", 32'(o_sbe[0]), 32'h1);
        chk("t4_s_address", 32'(o_saddr[0]), 32'h2000_0000);
        tick();
        clr_m(1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t4_no_dv", 32'(o_dv0[2] | o_dv1[2] | o_dv0[0] | o_dv1[0]), 32'd0);
            tick();
        end

        // Reset one cycle after an accepted read, latency 2.
        set_m(0, 30'h30, 1'b0, '0, 4'hF, 1'b1);
        tick();
        clr_m(0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t5_no_dv_lat2", 32'(o_dv0[1] | o_dv1[1]), 32'd0);
            tick();
        end
        set_m(0, 30'h100, 1'b0, '0, 4'hF, 1'b1);
        set_m(1, 30'h200, 1'b0, '0, 4'hF, 1'b1);
        @(negedge clk);
        chk("t5_contest_to_m0", 32'(o_saddr[0]), 32'h100);
        chk("t5_wait_m1", 32'(o_w1[0]), 32'd1);
        tick();
        clr_m(0);
        clr_m(1);
        tick();

        // Hold release: M0 drops after 3 cycles, M1 takes over at once.
        do_reset();
        set_m(0, 30'h40, 1'b1, 32'h1111_1111, 4'hF, 1'b0);
        set_m(1, 30'h50, 1'b1, 32'h2222_2222, 4'hF, 1'b0);
        for (int c = 0; c < 6; c++) begin
            if (c == 3) clr_m(0);
            @(negedge clk);
            gr[c] = (o_saddr[0] == 30'h40) ? 0 : (o_saddr[0] == 30'h50) ? 1 : -1;
            if (c == 2) chk("t6_hold_c2", 32'(g_dut[0].u_dut.hold_q), 32'd1);
            if (c == 4) chk("t6_hold_c4", 32'(g_dut[0].u_dut.hold_q), 32'd0);
            tick();
        end
        clr_m(1);
        chk("t6_grant_c0", 32'(gr[0]), 32'd0);
        chk("t6_grant_c2", 32'(gr[2]), 32'd0);
        chk("t6_grant_c3", 32'(gr[3]), 32'd1);
        chk("t6_grant_c5", 32'(gr[5]), 32'd1);

        for (int c = 0; c < 6; c++) tick();
        for (int k = 0; k < NInst; k++) chk("returns_drained", 32'(rq[k].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
